// File: rtl/mul_seq_32_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_32_if
// Description : Request/response bundle for the sequential 32x32 multiplier.
//               master : drives start/a/b and observes busy/done/p
//               slave  : the multiplier side
//   start  1   request pulse, accepted only while the multiplier is idle
//   a      32  multiplicand, sampled on the accepted start
//   b      32  multiplier, sampled on the accepted start
//   busy   1   multiplication in progress
//   done   1   one-cycle completion pulse
//   p      64  product, held from done until the next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_32_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );
endinterface : mul_seq_32_if
`default_nettype wire

// File: rtl/mul_seq_32.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_32 (with helper mul_seq_32_rca)
// Description : Radix-2 shift-add 32x32 -> 64 multiplier, one partial
//               product per clock.  Unsigned by default; defining the macro
//               MUL_SIGNED_EN selects two's-complement operands (magnitudes
//               are multiplied, then the product is negated in a NEG state).
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset
//   bus    slave modport of mul_seq_32_if (start, a, b, busy, done, p)
//   Latency from accepted start to done: 34 cycles unsigned, 35 signed.
// Revision    : 1.0 - initial release
// ============================================================================

// 32-bit ripple-carry adder built from a chain of full adders.
module mul_seq_32_rca (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_cin,
    output logic      [31:0] o_sum,
    output logic             o_cout
);
    logic [32:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
        assign o_sum[gi]      = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) |
                                 (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_carry[32];
endmodule : mul_seq_32_rca


module mul_seq_32 (
    input wire logic     clk,
    input wire logic     rst,
    mul_seq_32_if.slave  bus
);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [1:0] c_st_neg  = 2'd3;
`endif
    // Counter value at which all 32 partial products have been accumulated.
    localparam logic [5:0] c_last_cnt = 6'd32;

    logic [1:0]  r_state;
    logic [63:0] r_acc;     // {partial sum, remaining multiplier bits}
    logic [31:0] r_mcand;
    logic [5:0]  r_cnt;
    logic [63:0] r_p;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_sum;
    logic        w_cout;
    logic [63:0] w_step;
    logic [31:0] w_load_a;
    logic [31:0] w_load_b;

`ifdef MUL_SIGNED_EN
    logic        r_sign;
    logic [31:0] w_hi_sum;
    logic        w_hi_cout;
    logic [63:0] w_neg;
    logic [63:0] w_final;

    // The step adder is idle during NEG, so it is reused for the low half of
    // the two's-complement negation (~lo + 1); its carry feeds the high half.
    assign w_add_a = (r_state == c_st_neg) ? ~r_acc[31:0] : r_acc[63:32];
    assign w_add_b = (r_state == c_st_neg) ? 32'd1        : r_mcand;

    mul_seq_32_rca u_rca_hi (
        .i_a    (~r_acc[63:32]),
        .i_b    (32'd0),
        .i_cin  (w_cout),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    assign w_neg   = {w_hi_sum, w_sum};
    assign w_final = r_sign ? w_neg : r_acc;

    // Magnitudes: -2^31 negates to itself, which read unsigned is 2^31.
    assign w_load_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign w_load_b = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
`else
    assign w_add_a  = r_acc[63:32];
    assign w_add_b  = r_mcand;
    assign w_load_a = bus.a;
    assign w_load_b = bus.b;
`endif

    mul_seq_32_rca u_rca_step (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Conditional add then shift right; the adder carry becomes acc[63] so a
    // full 33-bit partial sum is never truncated.
    assign w_step = r_acc[0] ? {w_cout, w_sum, r_acc[31:1]}
                             : {1'b0, r_acc[63:32], r_acc[31:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_acc   <= 64'd0;
            r_mcand <= 32'd0;
            r_cnt   <= 6'd0;
            r_p     <= 64'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MUL_SIGNED_EN
            r_sign  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_mcand <= w_load_a;
                        r_acc   <= {32'd0, w_load_b};
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_run;
`ifdef MUL_SIGNED_EN
                        r_sign  <= bus.a[31] ^ bus.b[31];
`endif
                    end
                end

                c_st_run: begin
                    // Counter reaches 32 after the 32nd step; that cycle only
                    // hands the accumulated result on.
                    if (r_cnt == c_last_cnt) begin
`ifdef MUL_SIGNED_EN
                        r_state <= c_st_neg;
`else
                        r_p     <= r_acc;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_st_done;
`endif
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end

`ifdef MUL_SIGNED_EN
                c_st_neg: begin
                    r_acc   <= w_final;
                    r_p     <= w_final;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_done;
                end
`endif

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.p    = r_p;
endmodule : mul_seq_32
`default_nettype wire

// File: tb/tb_mul_seq_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_32
// Description : Self-checking bench for mul_seq_32.  Directed corner cases
//               plus random operands compared against an arithmetic model.
//               Honours MUL_SIGNED_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_32;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_seq_32_if bus ();

    mul_seq_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Index (in negedges after the start edge) of the cycle carrying done.
`ifdef MUL_SIGNED_EN
    localparam int c_lat = 34;
`else
    localparam int c_lat = 33;
`endif

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SIGNED_EN
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiplication and follow it to completion.  Optional extra
    // start pulses at cycle indices pulse1/pulse2; abort_k >= 0 asserts reset
    // at that cycle instead of waiting for done.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input string tag, input int pulse1, input int pulse2,
                          input int abort_k, input logic [63:0] exp);
        int          k;
        int          extra_done;
        bit          seen;
        bit          busy_ok;
        bit          p_ok;
        logic        busy_at_done;
        logic [63:0] p_before;

        p_before     = bus.p;
        busy_ok      = 1'b1;
        p_ok         = 1'b1;
        seen         = 1'b0;
        busy_at_done = 1'b1;
        extra_done   = 0;

        bus.a     = op_a;
        bus.b     = op_b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;

        k = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check({tag, "_abort_busy"}, {63'd0, bus.busy}, 64'd0);
                check({tag, "_abort_done"}, {63'd0, bus.done}, 64'd0);
                check({tag, "_abort_p"}, bus.p, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (bus.done === 1'b1) extra_done++;
                end
                check({tag, "_abort_no_done"}, 64'(extra_done), 64'd0);
                return;
            end
            if (bus.done === 1'b1) begin
                seen         = 1'b1;
                busy_at_done = bus.busy;
            end else begin
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (bus.p !== p_before) p_ok = 1'b0;
                if (k == pulse1 || k == pulse2) begin
                    bus.start = 1'b1;
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                end else begin
                    bus.start = 1'b0;
                end
                k++;
            end
        end
        bus.start = 1'b0;

        check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(c_lat));
        check({tag, "_p"}, bus.p, exp);
        check({tag, "_busy_at_done"}, {63'd0, busy_at_done}, 64'd0);
        check({tag, "_busy_during_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_p_stable_during_run"}, {63'd0, p_ok}, 64'd1);

        // done must be a single pulse and p must hold afterwards.
        p_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
            if (bus.p !== exp) p_ok = 1'b0;
        end
        check({tag, "_single_done"}, 64'(extra_done), 64'd0);
        check({tag, "_p_held"}, {63'd0, p_ok}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_p", bus.p, 64'd0);
        rst = 1'b0;

        // Start issued for the very first edge after reset release.
        run_op(32'd3, 32'd5, "mul_3x5", -1, -1, -1, 64'h0000_0000_0000_000F);

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones", -1, -1, -1, 64'd1);
`else
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones", -1, -1, -1, 64'hFFFF_FFFE_0000_0001);
`endif

        run_op(32'h1234_5678, 32'd0, "zero_b_ignored_starts", 5, 20, -1, 64'd0);

        run_op($urandom, $urandom, "abort", -1, -1, 10, 64'd0);
        run_op(32'd7, 32'd6, "after_abort", -1, -1, -1, 64'd42);

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, "signed_neg3x5", -1, -1, -1, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(32'h8000_0000, 32'h8000_0000, "signed_min_sq", -1, -1, -1, 64'h4000_0000_0000_0000);
`endif

        run_op(32'h8000_0000, 32'hFFFF_FFFF, "corner_msb", -1, -1, -1,
               ref_mul(32'h8000_0000, 32'hFFFF_FFFF));

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, $sformatf("rand%0d", i), -1, -1, -1, ref_mul(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule : tb_mul_seq_32
`default_nettype wire

// File: doc/mul_seq_32.md
MUL_SEQ_32 -- requirements
Module: mul_seq_32

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  Single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  Reset: asynchronous, active-high.
REQ-004 start  input  1  Request pulse; accepted only in IDLE.
REQ-005 a  input  32  Multiplicand; sampled on the accepted start.
REQ-006 b  input  32  Multiplier; sampled on the accepted start.
REQ-007 busy  output  1  High in RUN (and NEG, when configured).
REQ-008 done  output  1  One-cycle completion pulse.
REQ-009 p  output  64  Product; held stable from done until the next accepted start.

Function
REQ-010 The FSM SHALL use states IDLE, RUN and DONE, plus NEG when MUL_SIGNED_EN is defined.
REQ-011 In IDLE with start=1, the block SHALL make these updates at the clock edge:
- latch a into the multiplicand register (mcand);
- load acc[63:32]=0 and acc[31:0]=b;
- clear the iteration counter;
- enter RUN.
REQ-012 In RUN, each cycle SHALL perform one shift-add step:
- if acc[0]=1, {cout,sum} = acc[63:32] + mcand, using one instance of the team's 32-bit ripple full-adder chain with carry-in 0;
- otherwise {cout,sum} = {0, acc[63:32]};
- then acc = {cout, sum, acc[31:1]}.
REQ-013 The iteration counter SHALL be 6 bits wide and increment once per RUN cycle; after the 32nd RUN cycle the FSM SHALL go to DONE (or to NEG when configured).
REQ-014 On entry to DONE, p SHALL be loaded with acc; done SHALL be 1 for exactly that one cycle; DONE SHALL return to IDLE unconditionally.
REQ-015 Latency SHALL be 34 cycles unsigned: start sampled at edge N, done high during the cycle after edge N+33.
REQ-016 start SHALL be ignored when the FSM is in RUN, NEG or DONE; no operand is re-sampled.
REQ-017 busy SHALL equal (state==RUN || state==NEG); done and busy SHALL never be high together.
REQ-018 Unsigned results SHALL be exact for all 2^64 operand pairs; the carry out of the adder SHALL never be lost.
REQ-019 p SHALL NOT change in any state other than the DONE entry edge.

Reset
REQ-020 On rst=1, asynchronously and regardless of clk, the block SHALL set:
- state=IDLE;
- acc=0, mcand=0, counter=0;
- p=0, busy=0, done=0.
REQ-021 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-022 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-023 Macro MUL_SIGNED_EN SHALL select signed two's-complement operation.
REQ-024 With MUL_SIGNED_EN defined, the block SHALL behave as follows:
- at start, the block latches |a| and |b| as 32-bit unsigned values (−2^31 maps to 0x80000000) and records sign = a[31]^b[31];
- after RUN, the FSM enters NEG for one cycle and negates acc if sign=1, using two passes of the same 32-bit adder, low then high with carry chained (a single cycle is permitted if the implementation uses a second instance);
- latency is 35 cycles.
REQ-025 Without MUL_SIGNED_EN, the NEG state and sign logic SHALL be absent; operands are unsigned and latency is 34 cycles.

Verification
REQ-026 a=3, b=5, start at edge 0 -> done high in cycle 34, p=0x000000000000000F, busy low.
REQ-027 a=b=0xFFFFFFFF (unsigned) -> p=0xFFFFFFFE00000001; carry path exercised.
REQ-028 a=0x12345678, b=0 -> p=0; then start pulsed at RUN cycles 5 and 20 -> ignored, exactly one done, p unchanged from the first result.
REQ-029 rst asserted at RUN cycle 10 -> busy=0, p=0, no done; a new start with a=7, b=6 then gives p=42 at the normal latency.
REQ-030 With MUL_SIGNED_EN, the bench SHALL check these cases, each done at cycle 35:
- a=−3 (0xFFFFFFFD), b=5 -> p=0xFFFFFFFFFFFFFFF1;
- a=b=0x80000000 -> p=0x4000000000000000.
